// File: rtl/hs_tx_channel_pkg.sv
// ============================================================================
// Module : hs_tx_channel_pkg
// Brief  : Shared state encoding, default widths and width helper for hs_tx_*
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package hs_tx_channel_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ_HIGH = 2'd1,
        REQ_LOW  = 2'd2
    } hs_state_t;

    localparam int c_hs_default_data_w         = 8;
    localparam int c_hs_default_fifo_depth     = 4;
    localparam int c_hs_default_sync_stages    = 2;
    localparam int c_hs_default_timeout_cycles = 255;

    // Bits needed to hold values 0..value-1 (ceil(log2(value))).
    function automatic int hs_clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hs_tx_fifo.sv
// ============================================================================
// Module : hs_tx_fifo
// Brief  : Synchronous FIFO; full/empty derived from the occupancy count
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hs_tx_fifo
    import hs_tx_channel_pkg::*;
#(
    parameter int DATA_W     = c_hs_default_data_w,
    parameter int FIFO_DEPTH = c_hs_default_fifo_depth
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  push,
    input  logic                                  pop,
    input  logic [DATA_W-1:0]                     wdata,
    output logic [DATA_W-1:0]                     rdata,
    output logic [hs_clog2(FIFO_DEPTH + 1) - 1:0] level,
    output logic                                  full,
    output logic                                  empty
);

    localparam int c_ptr_w   = hs_clog2(FIFO_DEPTH);
    localparam int c_level_w = hs_clog2(FIFO_DEPTH + 1);

    logic [DATA_W-1:0]    r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_level_w-1:0] r_level;
    logic                 w_do_push;
    logic                 w_do_pop;

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + c_level_w'(1);
                2'b01:   r_level <= r_level - c_level_w'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    assign rdata = r_mem[r_rd_ptr];
    assign level = r_level;
    assign full  = (r_level == c_level_w'(FIFO_DEPTH));
    assign empty = (r_level == '0);

endmodule

`default_nettype wire

// File: rtl/hs_tx_channel.sv
// ============================================================================
// Module : hs_tx_channel
// Brief  : FIFO-buffered four-phase req/ack transmitter with ack synchroniser.
//          Define HS_TX_TIMEOUT_EN to build the REQ_HIGH handshake timeout.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hs_tx_channel
    import hs_tx_channel_pkg::*;
#(
    parameter int DATA_W         = c_hs_default_data_w,
    parameter int FIFO_DEPTH     = c_hs_default_fifo_depth,
    parameter int SYNC_STAGES    = c_hs_default_sync_stages,
    parameter int TIMEOUT_CYCLES = c_hs_default_timeout_cycles
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  in_valid,
    input  logic [DATA_W-1:0]                     in_data,
    output logic                                  in_ready,
    input  logic                                  ack,
    output logic                                  req,
    output logic [DATA_W-1:0]                     data,
    output logic [hs_clog2(FIFO_DEPTH + 1) - 1:0] level,
    output logic                                  busy,
    output logic                                  timeout_err
);

    localparam int c_level_w = hs_clog2(FIFO_DEPTH + 1);

    hs_state_t              r_state;
    hs_state_t              w_state_nxt;
    logic                   r_req;
    logic                   w_req_nxt;
    logic [DATA_W-1:0]      r_data;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_full;
    logic                   w_empty;
    logic [DATA_W-1:0]      w_head;
    logic [c_level_w-1:0]   w_level;
    logic [SYNC_STAGES-1:0] r_ack_sync;
    logic                   w_ack_s;
    logic                   w_tmo;

    assign w_push = in_valid && !w_full;

    hs_tx_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (in_data),
        .rdata (w_head),
        .level (w_level),
        .full  (w_full),
        .empty (w_empty)
    );

    if (SYNC_STAGES == 1) begin : g_sync_single
        always_ff @(posedge clk) begin
            if (reset) r_ack_sync <= '0;
            else        r_ack_sync <= ack;
        end
    end else begin : g_sync_chain
        always_ff @(posedge clk) begin
            if (reset) r_ack_sync <= '0;
            else        r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], ack};
        end
    end

    assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

`ifdef HS_TX_TIMEOUT_EN
    localparam int c_tmo_w = hs_clog2(TIMEOUT_CYCLES + 1);

    logic [c_tmo_w-1:0] r_tmo_cnt;
    logic               r_timeout_err;

    // Held at zero outside REQ_HIGH, so every entry starts a fresh count.
    assign w_tmo = (r_state == REQ_HIGH) && !w_ack_s &&
                   (r_tmo_cnt == c_tmo_w'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmo_cnt     <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_tmo;
            if (r_state != REQ_HIGH) begin
                r_tmo_cnt <= '0;
            end else if (!w_ack_s) begin
                r_tmo_cnt <= r_tmo_cnt + c_tmo_w'(1);
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    logic w_unused_timeout_cycles;

    assign w_unused_timeout_cycles = |32'(TIMEOUT_CYCLES);
    assign w_tmo                   = 1'b0;
    assign timeout_err             = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_req_nxt   = 1'b1;
                    w_state_nxt = REQ_HIGH;
                end
            end
            REQ_HIGH: begin
                // A timed-out word is dropped: it was already popped.
                if (w_ack_s || w_tmo) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = REQ_LOW;
                end
            end
            REQ_LOW: begin
                if (!w_ack_s) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_req_nxt   = 1'b1;
                        w_state_nxt = REQ_HIGH;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_req_nxt   = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            if (w_pop) begin
                r_data <= w_head;
            end
        end
    end

    assign req      = r_req;
    assign data     = r_data;
    assign level    = w_level;
    assign in_ready = !w_full;
    assign busy     = (r_state != IDLE) || (w_level != '0);

endmodule

`default_nettype wire

// File: tb/tb_hs_tx_channel.sv
// ============================================================================
// Module : tb_hs_tx_channel
// Brief  : Directed self-checking bench for hs_tx_channel (SYNC_STAGES=2).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hs_tx_channel;

    localparam int DATA_W         = 8;
    localparam int FIFO_DEPTH     = 4;
    localparam int SYNC_STAGES    = 2;
    localparam int TIMEOUT_CYCLES = 16;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic       ack      = 1'b0;
    logic       in_ready;
    logic       req;
    logic [7:0] data;
    logic [2:0] level;
    logic       busy;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hs_tx_channel #(
        .DATA_W         (DATA_W),
        .FIFO_DEPTH     (FIFO_DEPTH),
        .SYNC_STAGES    (SYNC_STAGES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .ack         (ack),
        .req         (req),
        .data        (data),
        .level       (level),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    // Receiver model: waits for req, acks after ack_dly, drops ack drop_dly after req falls.
    // got is X if req never rose; fall is 200 if req never fell.
    task automatic rx_handshake(input int ack_dly, input int drop_dly,
                                output logic [7:0] got, output bit stable, output int fall);
        int t;
        got = 8'hxx; stable = 1'b1; fall = 999; t = 0;
        while (req !== 1'b1 && t < 200) begin tick(); t++; end
        if (req === 1'b1) begin
            got = data;
            repeat (ack_dly) begin tick(); if (data !== got) stable = 1'b0; end
            ack = 1'b1; fall = 0;
            while (req !== 1'b0 && fall < 200) begin
                tick(); fall++;
                if (data !== got) stable = 1'b0;
            end
            repeat (drop_dly) begin tick(); if (data !== got) stable = 1'b0; end
            ack = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; ack = 1'b0;
        repeat (3) tick();
        checks++; if (req !== 1'b0)         begin errors++; $display("FAIL reset_req got %0b want 0", req); end
        checks++; if (data !== 8'h00)       begin errors++; $display("FAIL reset_data got %h want 00", data); end
        checks++; if (level !== 3'd0)       begin errors++; $display("FAIL reset_level got %0d want 0", level); end
        checks++; if (in_ready !== 1'b1)    begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got %0b want 0", timeout_err); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic [7:0] got; bit stable; int fall;
        in_data = 8'hA5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL single_level_e0 got %0d want 1", level); end
        checks++; if (req !== 1'b0)   begin errors++; $display("FAIL single_req_e0 got %0b want 0", req); end
        tick();
        checks++; if (req !== 1'b1)    begin errors++; $display("FAIL single_req_e1 got %0b want 1", req); end
        checks++; if (data !== 8'hA5)  begin errors++; $display("FAIL single_data_e1 got %h want a5", data); end
        rx_handshake(3, 2, got, stable, fall);
        checks++; if (got !== 8'hA5)   begin errors++; $display("FAIL single_rx_data got %h want a5", got); end
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL single_data_stable got %0b want 1", stable); end
        checks++; if (fall !== SYNC_STAGES + 1) begin errors++; $display("FAIL single_req_fall got %0d want %0d", fall, SYNC_STAGES + 1); end
        repeat (4) tick();
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL single_busy_end got %0b want 0", busy); end
        checks++; if (data !== 8'hA5)  begin errors++; $display("FAIL single_data_retained got %h want a5", data); end
    endtask

    task automatic test_fill();
        logic [7:0] got_arr [6];
        bit         stab_arr [6];
        int         fall;
        ack = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            in_data = 8'(k); in_valid = 1'b1;
            tick();
        end
        in_data = 8'h06;
        repeat (3) tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got %0b want 0", in_ready); end
        checks++; if (level !== 3'd4)    begin errors++; $display("FAIL fill_level got %0d want 4", level); end
        checks++; if (data !== 8'h01)    begin errors++; $display("FAIL fill_head_data got %h want 01", data); end
        checks++; if (req !== 1'b1)      begin errors++; $display("FAIL fill_req got %0b want 1", req); end
        fork
            begin
                int t;
                t = 0;
                while (in_ready !== 1'b1 && t < 200) begin tick(); t++; end
                tick();
                in_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 6; k++) rx_handshake(1, 1, got_arr[k], stab_arr[k], fall);
            end
        join
        for (int k = 0; k < 6; k++) begin
            checks++; if (got_arr[k] !== 8'(k + 1)) begin errors++; $display("FAIL fill_order[%0d] got %h want %h", k, got_arr[k], 8'(k + 1)); end
        end
        repeat (4) tick();
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL fill_level_end got %0d want 0", level); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL fill_busy_end got %0b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int t; int gap; logic [7:0] exp;
        ack = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            in_data = 8'(8'h11 * k); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        checks++; if (level !== 3'd2) begin errors++; $display("FAIL b2b_preload_level got %0d want 2", level); end
        for (int w = 0; w < 3; w++) begin
            exp = 8'(8'h11 * (w + 1));
            t = 0;
            while (req !== 1'b1 && t < 50) begin tick(); t++; end
            checks++; if (data !== exp) begin errors++; $display("FAIL b2b_data[%0d] got %h want %h", w, data, exp); end
            ack = 1'b1;
            t = 0;
            while (req !== 1'b0 && t < 50) begin tick(); t++; end
            ack = 1'b0;
            if (w < 2) begin
                gap = 0;
                while (req !== 1'b1 && gap < 50) begin tick(); gap++; end
                checks++; if (gap !== SYNC_STAGES + 1) begin errors++; $display("FAIL b2b_gap[%0d] got %0d want %0d", w, gap, SYNC_STAGES + 1); end
            end
        end
        repeat (4) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end got %0b want 0", busy); end
    endtask

    task automatic test_simul_push_pop();
        int t; logic [7:0] got; bit stable; int fall; logic [7:0] exp;
        ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_data = (k == 0) ? 8'hA1 : (k == 1) ? 8'hB2 : 8'hC3; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        checks++; if (level !== 3'd2)   begin errors++; $display("FAIL simul_pre_level got %0d want 2", level); end
        checks++; if (data !== 8'hA1)   begin errors++; $display("FAIL simul_pre_data got %h want a1", data); end
        ack = 1'b1;
        t = 0;
        while (req !== 1'b0 && t < 50) begin tick(); t++; end
        ack = 1'b0;
        tick(); tick();
        in_data = 8'hD4; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (level !== 3'd2)   begin errors++; $display("FAIL simul_level got %0d want 2", level); end
        checks++; if (req !== 1'b1)     begin errors++; $display("FAIL simul_req got %0b want 1", req); end
        checks++; if (data !== 8'hB2)   begin errors++; $display("FAIL simul_data got %h want b2", data); end
        for (int k = 0; k < 3; k++) begin
            exp = (k == 0) ? 8'hB2 : (k == 1) ? 8'hC3 : 8'hD4;
            rx_handshake(2, 1, got, stable, fall);
            checks++; if (got !== exp) begin errors++; $display("FAIL simul_order[%0d] got %h want %h", k, got, exp); end
        end
        repeat (4) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL simul_busy_end got %0b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        ack = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            in_data = 8'(8'h40 + k); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        checks++; if (level !== 3'd3) begin errors++; $display("FAIL rmid_pre_level got %0d want 3", level); end
        checks++; if (req !== 1'b1)   begin errors++; $display("FAIL rmid_pre_req got %0b want 1", req); end
        reset = 1'b1;
        tick();
        checks++; if (req !== 1'b0)      begin errors++; $display("FAIL rmid_req got %0b want 0", req); end
        checks++; if (data !== 8'h00)    begin errors++; $display("FAIL rmid_data got %h want 00", data); end
        checks++; if (level !== 3'd0)    begin errors++; $display("FAIL rmid_level got %0d want 0", level); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got %0b want 1", in_ready); end
        reset = 1'b0;
        tick();
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rmid_busy got %0b want 0", busy); end
    endtask

    task automatic test_timeout();
        logic [7:0] got; bit stable; int fall;
        ack = 1'b0;
        in_data = 8'h5A; in_valid = 1'b1; tick();
        in_data = 8'h6B; tick();
        in_valid = 1'b0;
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL tmo_req_rise got %0b want 1", req); end
`ifdef HS_TX_TIMEOUT_EN
        begin
            int n;
            n = 0;
            while (req === 1'b1 && n < 100) begin tick(); n++; end
            checks++; if (n !== TIMEOUT_CYCLES) begin errors++; $display("FAIL tmo_req_drop got %0d want %0d", n, TIMEOUT_CYCLES); end
            checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_err_pulse got %0b want 1", timeout_err); end
            tick();
            checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_err_width got %0b want 0", timeout_err); end
            checks++; if (req !== 1'b1)         begin errors++; $display("FAIL tmo_next_req got %0b want 1", req); end
            checks++; if (data !== 8'h6B)       begin errors++; $display("FAIL tmo_next_data got %h want 6b", data); end
            rx_handshake(1, 1, got, stable, fall);
            checks++; if (got !== 8'h6B) begin errors++; $display("FAIL tmo_drain got %h want 6b", got); end
        end
`else
        begin
            bit err_seen;
            err_seen = 1'b0;
            repeat (40) begin tick(); if (timeout_err !== 1'b0) err_seen = 1'b1; end
            checks++; if (req !== 1'b1)      begin errors++; $display("FAIL notmo_req_held got %0b want 1", req); end
            checks++; if (err_seen !== 1'b0) begin errors++; $display("FAIL notmo_err_seen got %0b want 0", err_seen); end
            rx_handshake(1, 1, got, stable, fall);
            checks++; if (got !== 8'h5A) begin errors++; $display("FAIL notmo_drain0 got %h want 5a", got); end
            rx_handshake(1, 1, got, stable, fall);
            checks++; if (got !== 8'h6B) begin errors++; $display("FAIL notmo_drain1 got %h want 6b", got); end
        end
`endif
        repeat (4) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_busy_end got %0b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_simul_push_pop();
        test_reset_mid();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
